// File: rtl/io_in_feeder.sv
// Purpose : per-channel sample FIFOs feeding the processor's 13-bit signed io_in on one-hot req_in strobes.
// Latency : write visible to a read one cycle after wr_en; read is zero-latency (io_in combinational, pop at the edge).
// Backpr. : no stall; writes to a full channel are dropped (overflow), reads of an empty channel return 0 (underflow).
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   wr_en/wr_ch/wr_data acquisition-side write into channel wr_ch
//   req_in             one-hot read request; lowest set bit wins
//   io_in              head sample of the selected channel, 0 when none/empty/reset
//   full, empty        per-channel status from registered pointers
//   overflow/underflow per-channel sticky error flags, cleared by clr_flags
module io_in_feeder #(
  parameter int NBITS = 13,
  parameter int NCH   = 4,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(NCH)-1:0]   wr_ch,
  input  logic signed [NBITS-1:0]  wr_data,
  input  logic [NCH-1:0]           req_in,
  output logic signed [NBITS-1:0]  io_in,
  output logic [NCH-1:0]           full,
  output logic [NCH-1:0]           empty,
  output logic [NCH-1:0]           overflow,
  output logic [NCH-1:0]           underflow,
  input  logic                     clr_flags
);

  localparam int CW = $clog2(NCH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Storage is never reset; only the pointers define what is valid.
  logic signed [NBITS-1:0] mem [NCH][DEPTH];

  // One extra MSB per pointer distinguishes full from empty.
  logic [AW:0] wp [NCH];
  logic [AW:0] rp [NCH];

  logic [CW-1:0]  sel;
  logic           req_any;
  logic           pop;
  logic           push;
  logic           same_ch;
  logic           ovf_ev;
  logic           udf_ev;
  logic [NCH-1:0] ovf_set;
  logic [NCH-1:0] udf_set;

  for (genvar g = 0; g < NCH; g++) begin : g_status
    assign empty[g] = (wp[g] == rp[g]);
    assign full[g]  = (wp[g][AW-1:0] == rp[g][AW-1:0]) && (wp[g][AW] != rp[g][AW]);
  end

  // Lowest set request bit selects the channel; higher bits are ignored.
  always_comb begin
    sel = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req_in[i]) sel = CW'(i);
    end
  end

  assign req_any = |req_in;
  assign same_ch = (sel == wr_ch);
  assign pop     = !rst && req_any && !empty[sel];
  assign udf_ev  = !rst && req_any && empty[sel];

  // A pop on the same full channel frees a slot in the same cycle, so the write is taken.
  assign push    = !rst && wr_en && (!full[wr_ch] || (pop && same_ch));
  assign ovf_ev  = !rst && wr_en && full[wr_ch] && !(pop && same_ch);

  // No fall-through: an empty channel reads 0 even if it is being written this cycle.
  assign io_in   = pop ? mem[sel][rp[sel][AW-1:0]] : '0;

  always_comb begin
    ovf_set = '0;
    udf_set = '0;
    if (ovf_ev) ovf_set[wr_ch] = 1'b1;
    if (udf_ev) udf_set[sel]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ch][wp[wr_ch][AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
      end
      overflow  <= '0;
      underflow <= '0;
    end else begin
      if (push) wp[wr_ch] <= wp[wr_ch] + PTR_ONE;
      if (pop)  rp[sel]   <= rp[sel] + PTR_ONE;
      // A new event in the clearing cycle keeps its flag set.
      overflow  <= (clr_flags ? '0 : overflow)  | ovf_set;
      underflow <= (clr_flags ? '0 : underflow) | udf_set;
    end
  end

endmodule

// File: tb/tb_io_in_feeder.sv
// Purpose : directed self-checking bench for io_in_feeder.
// Latency : inputs applied at negedge, io_in checked 1ns later, registered state checked after the next edge.
// Backpr. : n/a (bench drives the DUT directly).
module tb_io_in_feeder;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               wr_en = 1'b0;
  logic [1:0]         wr_ch = '0;
  logic signed [12:0] wr_data = '0;
  logic [3:0]         req_in = '0;
  logic signed [12:0] io_in;
  logic [3:0]         full;
  logic [3:0]         empty;
  logic [3:0]         overflow;
  logic [3:0]         underflow;
  logic               clr_flags = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  io_in_feeder #(.NBITS(13), .NCH(4), .DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .req_in(req_in), .io_in(io_in), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow), .clr_flags(clr_flags)
  );

  // Drive one cycle of inputs at the falling edge; returns 1ns later.
  task automatic apply(input logic we, input logic [1:0] ch, input int d,
                       input logic [3:0] rq, input logic cf);
    @(negedge clk);
    wr_en = we; wr_ch = ch; wr_data = 13'(d); req_in = rq; clr_flags = cf;
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 2'd0, 0, 4'b0000, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_in = 4'b0001;
    #1;
    total++; if (io_in !== 13'sd0) begin bad++; $display("FAIL reset_io_in got=%0d want=0", io_in); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; req_in = 4'b0000;
    #1;
    total++; if (empty !== 4'hF) begin bad++; $display("FAIL reset_empty got=%b want=1111", empty); end
    total++; if (full !== 4'h0) begin bad++; $display("FAIL reset_full got=%b want=0000", full); end
    total++; if (overflow !== 4'h0 || underflow !== 4'h0) begin bad++; $display("FAIL reset_flags got=%b/%b want=0000/0000", overflow, underflow); end
  endtask

  task automatic test_basic_order();
    apply(1'b1, 2'd0, 5, 4'b0000, 1'b0);
    apply(1'b1, 2'd0, -3, 4'b0000, 1'b0);
    apply(1'b1, 2'd0, 4095, 4'b0000, 1'b0);
    apply(1'b0, 2'd0, 0, 4'b0001, 1'b0);
    total++; if (io_in !== 13'(5)) begin bad++; $display("FAIL basic_rd0 got=%0d want=5", io_in); end
    apply(1'b0, 2'd0, 0, 4'b0001, 1'b0);
    total++; if (io_in !== 13'(-3)) begin bad++; $display("FAIL basic_rd1 got=%0d want=-3", io_in); end
    apply(1'b0, 2'd0, 0, 4'b0001, 1'b0);
    total++; if (io_in !== 13'(4095)) begin bad++; $display("FAIL basic_rd2 got=%0d want=4095", io_in); end
    idle();
    total++; if (empty[0] !== 1'b1) begin bad++; $display("FAIL basic_empty got=%b want=1", empty[0]); end
    total++; if (overflow !== 4'h0 || underflow !== 4'h0) begin bad++; $display("FAIL basic_flags got=%b/%b want=0000/0000", overflow, underflow); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 17; i++) begin
      apply(1'b1, 2'd2, i, 4'b0000, 1'b0);
      if (i == 16) begin
        total++; if (full[2] !== 1'b1) begin bad++; $display("FAIL fill_full16 got=%b want=1", full[2]); end
        total++; if (overflow[2] !== 1'b0) begin bad++; $display("FAIL fill_no_ovf16 got=%b want=0", overflow[2]); end
      end
    end
    idle();
    total++; if (overflow !== 4'b0100) begin bad++; $display("FAIL fill_ovf got=%b want=0100", overflow); end
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 2'd0, 0, 4'b0100, 1'b0);
      total++; if (io_in !== 13'(i)) begin bad++; $display("FAIL fill_rd%0d got=%0d want=%0d", i, io_in, i); end
    end
    idle();
    total++; if (empty[2] !== 1'b1) begin bad++; $display("FAIL fill_drained got=%b want=1", empty[2]); end
    apply(1'b0, 2'd0, 0, 4'b0000, 1'b1);
    idle();
    total++; if (overflow !== 4'h0) begin bad++; $display("FAIL fill_clr got=%b want=0000", overflow); end
  endtask

  task automatic test_underflow_clear();
    apply(1'b0, 2'd0, 0, 4'b1000, 1'b0);
    total++; if (io_in !== 13'sd0) begin bad++; $display("FAIL udf_io_in got=%0d want=0", io_in); end
    idle();
    total++; if (underflow !== 4'b1000) begin bad++; $display("FAIL udf_set got=%b want=1000", underflow); end
    total++; if (empty[3] !== 1'b1) begin bad++; $display("FAIL udf_empty got=%b want=1", empty[3]); end
    apply(1'b0, 2'd0, 0, 4'b0000, 1'b1);
    idle();
    total++; if (underflow !== 4'h0) begin bad++; $display("FAIL udf_clr got=%b want=0000", underflow); end
    // New event in the clearing cycle must win.
    apply(1'b0, 2'd0, 0, 4'b1000, 1'b1);
    idle();
    total++; if (underflow !== 4'b1000) begin bad++; $display("FAIL udf_set_over_clr got=%b want=1000", underflow); end
    apply(1'b0, 2'd0, 0, 4'b0000, 1'b1);
    // Pointers unchanged: one write then one read returns exactly that word.
    apply(1'b1, 2'd3, 42, 4'b0000, 1'b0);
    apply(1'b0, 2'd0, 0, 4'b1000, 1'b0);
    total++; if (io_in !== 13'(42)) begin bad++; $display("FAIL udf_ptr_rd got=%0d want=42", io_in); end
    idle();
    total++; if (empty[3] !== 1'b1 || underflow !== 4'h0) begin bad++; $display("FAIL udf_ptr_state got=%b/%b want=1/0000", empty[3], underflow); end
  endtask

  task automatic test_simul_empty();
    apply(1'b1, 2'd1, 7, 4'b0010, 1'b0);
    total++; if (io_in !== 13'sd0) begin bad++; $display("FAIL sim_empty_io_in got=%0d want=0", io_in); end
    idle();
    total++; if (underflow !== 4'b0010) begin bad++; $display("FAIL sim_empty_udf got=%b want=0010", underflow); end
    total++; if (empty[1] !== 1'b0) begin bad++; $display("FAIL sim_empty_stored got=%b want=0", empty[1]); end
    apply(1'b0, 2'd0, 0, 4'b0010, 1'b1);
    total++; if (io_in !== 13'(7)) begin bad++; $display("FAIL sim_empty_rd got=%0d want=7", io_in); end
    idle();
    total++; if (empty[1] !== 1'b1 || underflow !== 4'h0) begin bad++; $display("FAIL sim_empty_after got=%b/%b want=1/0000", empty[1], underflow); end
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < 16; i++) apply(1'b1, 2'd1, i, 4'b0000, 1'b0);
    apply(1'b1, 2'd1, 99, 4'b0010, 1'b0);
    total++; if (full[1] !== 1'b1) begin bad++; $display("FAIL sim_full_pre got=%b want=1", full[1]); end
    total++; if (io_in !== 13'sd0) begin bad++; $display("FAIL sim_full_io_in got=%0d want=0", io_in); end
    idle();
    total++; if (overflow !== 4'h0) begin bad++; $display("FAIL sim_full_ovf got=%b want=0000", overflow); end
    total++; if (full[1] !== 1'b1) begin bad++; $display("FAIL sim_full_stays got=%b want=1", full[1]); end
    for (int i = 1; i <= 16; i++) begin
      apply(1'b0, 2'd0, 0, 4'b0010, 1'b0);
      total++; if (io_in !== 13'((i == 16) ? 99 : i)) begin bad++; $display("FAIL sim_full_rd%0d got=%0d want=%0d", i, io_in, (i == 16) ? 99 : i); end
    end
    idle();
    total++; if (empty[1] !== 1'b1 || overflow !== 4'h0 || underflow !== 4'h0) begin bad++; $display("FAIL sim_full_after got=%b/%b/%b want=1/0000/0000", empty[1], overflow, underflow); end
  endtask

  task automatic test_multi_hot_wrap();
    apply(1'b1, 2'd0, 10, 4'b0000, 1'b0);
    apply(1'b1, 2'd2, 20, 4'b0000, 1'b0);
    apply(1'b0, 2'd0, 0, 4'b0101, 1'b0);
    total++; if (io_in !== 13'(10)) begin bad++; $display("FAIL multi_rd got=%0d want=10", io_in); end
    idle();
    total++; if (empty[0] !== 1'b1 || empty[2] !== 1'b0) begin bad++; $display("FAIL multi_pop got=%b want=x0x1 pattern (e0=1,e2=0)", empty); end
    apply(1'b0, 2'd0, 0, 4'b0100, 1'b0);
    total++; if (io_in !== 13'(20)) begin bad++; $display("FAIL multi_rd2 got=%0d want=20", io_in); end
    for (int i = 0; i < 40; i++) begin
      apply(1'b1, 2'd0, i * 37 - 700, 4'b0000, 1'b0);
      apply(1'b0, 2'd0, 0, 4'b0001, 1'b0);
      total++; if (io_in !== 13'(i * 37 - 700)) begin bad++; $display("FAIL wrap_rd%0d got=%0d want=%0d", i, io_in, i * 37 - 700); end
    end
    idle();
    total++; if (empty !== 4'hF || overflow !== 4'h0 || underflow !== 4'h0) begin bad++; $display("FAIL wrap_after got=%b/%b/%b want=1111/0000/0000", empty, overflow, underflow); end
  endtask

  task automatic test_midstream_reset();
    apply(1'b1, 2'd0, 1, 4'b0000, 1'b0);
    apply(1'b1, 2'd0, 2, 4'b0000, 1'b0);
    apply(1'b1, 2'd0, 3, 4'b0000, 1'b0);
    @(negedge clk);
    wr_en = 1'b0; rst = 1'b1; req_in = 4'b0001;
    #1;
    total++; if (io_in !== 13'sd0) begin bad++; $display("FAIL mid_rst_io_in got=%0d want=0", io_in); end
    @(negedge clk);
    rst = 1'b0; req_in = 4'b0000;
    #1;
    total++; if (empty !== 4'hF) begin bad++; $display("FAIL mid_rst_empty got=%b want=1111", empty); end
    apply(1'b0, 2'd0, 0, 4'b0001, 1'b0);
    total++; if (io_in !== 13'sd0) begin bad++; $display("FAIL mid_rst_rd got=%0d want=0", io_in); end
    idle();
    total++; if (underflow !== 4'b0001) begin bad++; $display("FAIL mid_rst_udf got=%b want=0001", underflow); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_order();
    test_fill_overflow();
    test_underflow_clear();
    test_simul_empty();
    test_simul_full();
    test_multi_hot_wrap();
    test_midstream_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_in_feeder.md
Name: io_in_feeder

Overview:
- Upstream feeder for the floating-point processor top level; drives its 13-bit signed integer input `io_in`.
- Buffers signed samples for NCH logical input channels, one circular FIFO per channel, loaded by the acquisition side.
- Serves the processor's one-hot `req_in` strobes by presenting the requested channel's head sample and popping it in the same cycle.

Parameters:
- NBITS, 13, sample width; matches processor integer input width.
- NCH, 4, number of input channels; matches width of `req_in`.
- DEPTH, 16, words per channel FIFO; must be a power of 2, at least 2.
- AW, 4, log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe from the acquisition side.
- wr_ch  input  2  target channel index for the write (log2 NCH bits).
- wr_data  input  NBITS  signed sample to enqueue.
- req_in  input  NCH  one-hot read request from the processor.
- io_in  output  NBITS  signed sample delivered to the processor.
- full  output  NCH  per-channel FIFO full.
- empty  output  NCH  per-channel FIFO empty.
- overflow  output  NCH  sticky flag: a write was dropped.
- underflow  output  NCH  sticky flag: a read hit an empty FIFO.
- clr_flags  input  1  clears `overflow` and `underflow`.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All read/write pointers go to 0; every channel is empty.
  - `overflow` and `underflow` go to 0.
  - Memory contents are not cleared.
  - While rst=1, `io_in` is forced to 0 and no read or write takes effect.
  - Reset asserted mid-stream discards all buffered data.
- Pointers: each channel keeps AW+1-bit `wp` and `rp`.
  - empty = (wp == rp).
  - full = (low AW bits equal) and (MSBs differ).
  - Both pointers wrap naturally modulo 2*DEPTH.
- Write:
  - When wr_en=1 and the target is not full, mem[wr_ch][wp] <= wr_data and wp increments.
  - When the target is full, the word is dropped and overflow[wr_ch] is set.
- Read channel selection: the lowest set bit of `req_in`. Other set bits are ignored and their FIFOs are not popped.
- Read timing (zero latency): `io_in` is combinational.
  - It equals mem[sel][rp] when req_in != 0 and the selected channel is not empty.
  - Otherwise it is 0.
  - The processor samples `io_in` in the same cycle it asserts `req_in`.
- Pop: at the edge ending a request cycle on a non-empty channel, rp[sel] increments.
- Empty read: `io_in` = 0, no pointer change, and underflow[sel] is set at that edge.
- Simultaneous read and write on the same channel, with the channel empty:
  - The read is an underflow and returns 0. There is no fall-through.
  - The write is stored; the channel is non-empty in the next cycle.
- Simultaneous read and write on the same channel, with the channel full: the pop frees a slot, so the write is accepted, wp and rp both increment, and no overflow is flagged.
- Simultaneous read and write on different channels: the two operations are independent.
- Flag priority: clr_flags=1 clears all sticky flags at the edge. A new overflow/underflow event in that same cycle wins and the flag stays set (set over clear).
- `full` and `empty` are derived combinationally from registered pointers, so they reflect state after the previous edge.
- Sample values pass through unmodified; sign is preserved bit-exactly.

Test Plan:
- Reset then basic FIFO order:
  - Stimulus: rst for 2 cycles; write 5, -3, 4095 to ch0; then req_in=0001 for 3 consecutive cycles.
  - Response: io_in = 5, -3, 4095 in those cycles; empty[0]=1 afterwards; no flags set.
- Fill and overflow:
  - Stimulus: 17 writes (values 0..16) to ch2.
  - Response: full[2]=1 after the 16th write; overflow[2]=1 after the 17th; reads return 0..15; value 16 is never delivered.
- Underflow and clear:
  - Stimulus: req_in=1000 with ch3 empty; then clr_flags=1 for one cycle.
  - Response: io_in=0 and underflow[3]=1 after the read edge; underflow[3]=0 after the clear; pointers unchanged.
- Simultaneous events, empty case:
  - Stimulus: ch1 empty; write 7 to ch1 in the same cycle as req_in=0010.
  - Response: io_in=0 and underflow[1]=1; the next req_in=0010 returns 7.
- Simultaneous events, full case:
  - Stimulus: ch1 full with 0..15; write 99 with req_in=0010 in the same cycle.
  - Response: io_in=0; no overflow; full[1] stays 1; the subsequent 16 reads return 1..15 then 99.
- Multi-hot request and wrap-around:
  - Stimulus: ch0 holds {10}, ch2 holds {20}; req_in=0101.
  - Response: io_in=10 and only ch0 pops; a following req_in=0100 returns 20.
  - Stimulus: 40 interleaved write/read pairs on ch0.
  - Response: pointers wrap and data is returned in order with no flags set.
- Mid-stream reset:
  - Stimulus: ch0 holds 3 words; assert rst for 1 cycle.
  - Response: all empty=1; io_in=0 during rst; a subsequent read gives io_in=0 and sets underflow[0].
